// File: rtl/proc_pkg.sv
// Shared opcode constants, FSM state type and decode helpers for the execution unit.
package proc_pkg;

    localparam int DATA_W = 16;

    localparam logic [4:0] OP_LL   = 5'b01010;
    localparam logic [4:0] OP_LH   = 5'b01011;
    localparam logic [4:0] OP_CMP  = 5'b00110;
    localparam logic [4:0] OP_CMPR = 5'b00111;
    localparam logic [4:0] OP_ADD  = 5'b10000;
    localparam logic [4:0] OP_ADDR = 5'b10001;
    localparam logic [4:0] OP_SUB  = 5'b10010;
    localparam logic [4:0] OP_SUBR = 5'b10011;
    localparam logic [4:0] OP_SHL  = 5'b10100;
    localparam logic [4:0] OP_SHR  = 5'b10101;
    localparam logic [4:0] OP_AND  = 5'b10110;
    localparam logic [4:0] OP_NOT  = 5'b10111;
    localparam logic [4:0] OP_OR   = 5'b11000;
    localparam logic [4:0] OP_XOR  = 5'b11001;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              wr;
        logic              illegal;
    } result_t;

    // Shift distance saturates at the word width; larger amounts give the same result.
    function automatic logic [4:0] shift_amount(input logic [DATA_W-1:0] b);
        return (b > 16'd16) ? 5'd16 : b[4:0];
    endfunction

endpackage

// File: rtl/iter_shifter.sv
// One-bit-per-cycle shifter: logical left or arithmetic right, with a remaining-step counter.
module iter_shifter
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_right,
    input  logic [DATA_W-1:0] i_value,
    input  logic [4:0]        i_amount,
    output logic [DATA_W-1:0] o_result,
    output logic              o_done
);

    logic [DATA_W-1:0] r_value;
    logic [4:0]        r_count;
    logic              r_right;
    logic [DATA_W-1:0] w_step;

    assign w_step = r_right ? {r_value[DATA_W-1], r_value[DATA_W-1:1]}
                            : {r_value[DATA_W-2:0], 1'b0};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_count <= '0;
            r_right <= 1'b0;
        end else if (i_load) begin
            r_value <= i_value;
            r_count <= i_amount;
            r_right <= i_right;
        end else if (r_count != 5'd0) begin
            r_value <= w_step;
            r_count <= r_count - 5'd1;
        end
    end

    // The final value is presented during the last step so it can be committed on that edge.
    assign o_result = (r_count != 5'd0) ? w_step : r_value;
    assign o_done   = (r_count <= 5'd1);

endmodule

// File: rtl/ex_unit.sv
// Execution unit: single-cycle ALU ops, iterative shifts, compare flags, valid/ready result port.
module ex_unit
    import proc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_opcode,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_wr,
    output logic                     out_illegal,
    output logic [2:0]               flags
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_out_valid;
    result_t           r_out;
    logic [2:0]        r_flags;

    result_t           w_res;
    logic              w_is_cmp;
    logic              w_is_shift;
    logic [4:0]        w_amount;
    logic              w_accept;
    logic              w_start_shift;
    logic              w_out_free;
    logic              w_shift_commit;
    logic [DATA_W-1:0] w_sh_result;
    logic              w_sh_done;

    assign w_out_free     = !r_out_valid || out_ready;
    assign in_ready       = !rst && (r_state == IDLE) && w_out_free;
    assign w_accept       = in_valid && in_ready;
    assign w_amount       = shift_amount(in_b);
    assign w_start_shift  = w_accept && w_is_shift && (w_amount != 5'd0);
    assign w_shift_commit = (r_state == SHIFT) && w_sh_done && w_out_free;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_res      = '0;
        w_is_cmp   = 1'b0;
        w_is_shift = 1'b0;
        case (in_opcode)
            OP_LL:            begin w_res.data = {in_a[15:8], in_b[7:0]}; w_res.wr = 1'b1; end
            OP_LH:            begin w_res.data = {in_b[15:8], in_a[7:0]}; w_res.wr = 1'b1; end
            OP_CMP, OP_CMPR:  w_is_cmp = 1'b1;
            OP_ADD, OP_ADDR:  begin w_res.data = in_a + in_b;  w_res.wr = 1'b1; end
            OP_SUB, OP_SUBR:  begin w_res.data = in_a - in_b;  w_res.wr = 1'b1; end
            OP_AND:           begin w_res.data = in_a & in_b;  w_res.wr = 1'b1; end
            OP_NOT:           begin w_res.data = ~in_a;        w_res.wr = 1'b1; end
            OP_OR:            begin w_res.data = in_a | in_b;  w_res.wr = 1'b1; end
            OP_XOR:           begin w_res.data = in_a ^ in_b;  w_res.wr = 1'b1; end
            // A zero-distance shift returns a unchanged on the single-cycle path.
            OP_SHL, OP_SHR:   begin w_res.data = in_a; w_res.wr = 1'b1; w_is_shift = 1'b1; end
            default:          w_res.illegal = 1'b1;
        endcase
    end

    iter_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_start_shift),
        .i_right  (in_opcode == OP_SHR),
        .i_value  (in_a),
        .i_amount (w_amount),
        .o_result (w_sh_result),
        .o_done   (w_sh_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_shift)  w_state_next = SHIFT;
            SHIFT:   if (w_shift_commit) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output register: a new beat may only load when the previous one is absent or leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_accept && !w_start_shift) begin
            r_out_valid <= 1'b1;
            r_out       <= w_res;
        end else if (w_shift_commit) begin
            r_out_valid <= 1'b1;
            r_out       <= '{data: w_sh_result, wr: 1'b1, illegal: 1'b0};
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else if (w_accept && w_is_cmp) begin
            r_flags <= {in_a < in_b, in_a == in_b, in_a > in_b};
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out.data;
    assign out_wr      = r_out.wr;
    assign out_illegal = r_out.illegal;
    assign flags       = r_flags;

endmodule
